// File: rtl/push_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : push_scheduler
// Purpose  : Sequences the dual particle pusher over a run of timesteps. Each
//            step streams particle pairs from particle memory into the pusher,
//            follows them with noop flush cycles to drain the pipeline, counts
//            retired pairs from the pusher's done pulses and then hands back to
//            the field solver. Issue is held off while a UART bmag upload owns
//            the shared bmag BRAM port.
// Ports    : clk_i          system clock, rising edge
//            rst_ni         asynchronous active-low reset
//            start_i        run start pulse (accepted only in IDLE, ui_busy low)
//            num_pairs_i    pairs per step, sampled on accepted start
//            num_steps_i    steps per run, sampled on accepted start
//            solver_ready_i field grid valid for the next push
//            ui_busy_i      UART bmag upload in progress
//            prd_en_o       particle memory read enable
//            prd_addr_o     particle pair read address
//            push_valid_o   pusher valid (aligned with memory read data)
//            push_noop_o    pusher noop (flush cycle)
//            push_done_i    pusher retired one non-noop pair
//            step_done_o    one-cycle pulse at end of each step
//            all_done_o     one-cycle pulse at end of run
//            busy_o         high in every state except IDLE
//            step_count_o   completed steps in the current run
//            err_o          sticky: done pulse with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module push_scheduler #(
  parameter int PADDR_W   = 16,
  parameter int STEP_W    = 16,
  parameter int FLUSH_LEN = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [PADDR_W-1:0] num_pairs_i,
  input  logic [STEP_W-1:0]  num_steps_i,
  input  logic               solver_ready_i,
  input  logic               ui_busy_i,
  output logic               prd_en_o,
  output logic [PADDR_W-1:0] prd_addr_o,
  output logic               push_valid_o,
  output logic               push_noop_o,
  input  logic               push_done_i,
  output logic               step_done_o,
  output logic               all_done_o,
  output logic               busy_o,
  output logic [STEP_W-1:0]  step_count_o,
  output logic               err_o
);

  localparam int FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_SOLVER = 3'd1,
    S_ISSUE       = 3'd2,
    S_FLUSH       = 3'd3,
    S_DRAIN       = 3'd4,
    S_STEP_END    = 3'd5,
    S_FINISH      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [PADDR_W-1:0] num_pairs_q, num_pairs_d;
  logic [STEP_W-1:0]  num_steps_q, num_steps_d;
  logic [PADDR_W-1:0] idx_q, idx_d;
  logic [PADDR_W-1:0] issued_q, issued_d;
  logic [PADDR_W-1:0] retired_q, retired_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [STEP_W-1:0]  step_count_q, step_count_d;
  logic               err_q, err_d;
  logic               push_valid_q, push_valid_d;
  logic               push_noop_q, push_noop_d;

  logic               rd_en;
  logic               flush_issue;
  logic               step_pulse;
  logic               done_pulse;

  always_comb begin
    state_d      = state_q;
    num_pairs_d  = num_pairs_q;
    num_steps_d  = num_steps_q;
    idx_d        = idx_q;
    issued_d     = issued_q;
    retired_d    = retired_q;
    flush_cnt_d  = flush_cnt_q;
    step_count_d = step_count_q;
    err_d        = err_q;
    rd_en        = 1'b0;
    flush_issue  = 1'b0;
    step_pulse   = 1'b0;
    done_pulse   = 1'b0;

    // A pair is issued to the pusher when its read data arrives, one cycle
    // after the read; noop flush beats do not count.
    if (push_valid_q && !push_noop_q) begin
      issued_d = issued_q + PADDR_W'(1);
    end

    // A done pulse with nothing outstanding is a pusher protocol fault; it is
    // flagged and not counted so the step can still complete.
    if ((state_q != S_IDLE) && push_done_i) begin
      if (retired_q == issued_q) begin
        err_d = 1'b1;
      end else begin
        retired_d = retired_q + PADDR_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !ui_busy_i) begin
          num_pairs_d  = num_pairs_i;
          num_steps_d  = num_steps_i;
          step_count_d = '0;
          err_d        = 1'b0;
          idx_d        = '0;
          issued_d     = '0;
          retired_d    = '0;
          if ((num_pairs_i == '0) || (num_steps_i == '0)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WAIT_SOLVER;
          end
        end
      end

      S_WAIT_SOLVER: begin
        if (solver_ready_i && !ui_busy_i) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!ui_busy_i) begin
          rd_en = 1'b1;
          idx_d = idx_q + PADDR_W'(1);
          if (idx_q == num_pairs_q - PADDR_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // Noops go through the same one-cycle output register as reads so
        // they follow the last data beat without a gap or overlap.
        if (!ui_busy_i) begin
          flush_issue = 1'b1;
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = S_DRAIN;
          end else begin
            flush_cnt_d = flush_cnt_q + FC_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (retired_q == issued_q) begin
          state_d = S_STEP_END;
        end
      end

      S_STEP_END: begin
        step_pulse   = 1'b1;
        step_count_d = step_count_q + STEP_W'(1);
        if (step_count_q + STEP_W'(1) == num_steps_q) begin
          state_d = S_FINISH;
        end else begin
          idx_d     = '0;
          issued_d  = '0;
          retired_d = '0;
          state_d   = S_WAIT_SOLVER;
        end
      end

      S_FINISH: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    push_valid_d = rd_en | flush_issue;
    push_noop_d  = flush_issue;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      num_pairs_q  <= '0;
      num_steps_q  <= '0;
      idx_q        <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      flush_cnt_q  <= '0;
      step_count_q <= '0;
      err_q        <= 1'b0;
      push_valid_q <= 1'b0;
      push_noop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_pairs_q  <= num_pairs_d;
      num_steps_q  <= num_steps_d;
      idx_q        <= idx_d;
      issued_q     <= issued_d;
      retired_q    <= retired_d;
      flush_cnt_q  <= flush_cnt_d;
      step_count_q <= step_count_d;
      err_q        <= err_d;
      push_valid_q <= push_valid_d;
      push_noop_q  <= push_noop_d;
    end
  end

  assign prd_en_o     = rd_en;
  assign prd_addr_o   = idx_q;
  assign push_valid_o = push_valid_q;
  assign push_noop_o  = push_noop_q;
  assign step_done_o  = step_pulse;
  assign all_done_o   = done_pulse;
  assign busy_o       = (state_q != S_IDLE);
  assign step_count_o = step_count_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_push_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_push_scheduler
// Purpose  : Directed self-checking bench for push_scheduler. A simple pusher
//            model retires each non-noop pair 12 cycles after it is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_push_scheduler;

  localparam int PADDR_W = 16;
  localparam int STEP_W  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic [PADDR_W-1:0] num_pairs_i;
  logic [STEP_W-1:0]  num_steps_i;
  logic               solver_ready_i;
  logic               ui_busy_i;
  logic               prd_en_o;
  logic [PADDR_W-1:0] prd_addr_o;
  logic               push_valid_o;
  logic               push_noop_o;
  logic               push_done_i;
  logic               step_done_o;
  logic               all_done_o;
  logic               busy_o;
  logic [STEP_W-1:0]  step_count_o;
  logic               err_o;

  push_scheduler #(.PADDR_W(PADDR_W), .STEP_W(STEP_W), .FLUSH_LEN(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .num_pairs_i    (num_pairs_i),
    .num_steps_i    (num_steps_i),
    .solver_ready_i (solver_ready_i),
    .ui_busy_i      (ui_busy_i),
    .prd_en_o       (prd_en_o),
    .prd_addr_o     (prd_addr_o),
    .push_valid_o   (push_valid_o),
    .push_noop_o    (push_noop_o),
    .push_done_i    (push_done_i),
    .step_done_o    (step_done_o),
    .all_done_o     (all_done_o),
    .busy_o         (busy_o),
    .step_count_o   (step_count_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  // Pusher model: fixed 12-cycle retire latency, plus an injectable extra pulse.
  logic [11:0] r_pipe = '0;
  logic        inj = 1'b0;
  always @(posedge clk) r_pipe <= {r_pipe[10:0], push_valid_o & ~push_noop_o};
  assign push_done_i = r_pipe[11] | inj;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  int addr_log[$];
  int rd_cyc[$];
  int pv_cnt, noop_cnt, sd_cnt, ad_cnt, rd_low;
  int first_pv, first_noop, last_noop;

  always @(negedge clk) begin
    if (prd_en_o) begin
      addr_log.push_back(int'(prd_addr_o));
      rd_cyc.push_back(cyc);
      if (!solver_ready_i) rd_low++;
    end
    if (push_valid_o && !push_noop_o) begin
      if (pv_cnt == 0) first_pv = cyc;
      pv_cnt++;
    end
    if (push_valid_o && push_noop_o) begin
      if (noop_cnt == 0) first_noop = cyc;
      last_noop = cyc;
      noop_cnt++;
    end
    if (step_done_o) sd_cnt++;
    if (all_done_o)  ad_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    addr_log.delete();
    rd_cyc.delete();
    pv_cnt = 0; noop_cnt = 0; sd_cnt = 0; ad_cnt = 0; rd_low = 0;
    first_pv = 0; first_noop = 0; last_noop = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_start(input int np, input int ns);
    num_pairs_i = PADDR_W'(np);
    num_steps_i = STEP_W'(ns);
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic wait_all(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (all_done_o) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (step_done_o) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_addrs(input string tag, input int np);
    chk({tag, "_nrd"}, 32'(addr_log.size()), 32'(np));
    for (int i = 0; i < np; i++) begin
      if (i < addr_log.size()) chk($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(i));
    end
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; start_i = 1'b0; num_pairs_i = '0; num_steps_i = '0;
    solver_ready_i = 1'b1; ui_busy_i = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_prd_en", 32'(prd_en_o), 0);
    chk("rst_push_valid", 32'(push_valid_o), 0);
    chk("rst_step_count", 32'(step_count_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start while an upload is active is dropped.
    ui_busy_i = 1'b1;
    do_start(4, 1);
    ui_busy_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("drop_start_busy", 32'(busy_o), 0);

    // 1: four pairs, one step.
    clear_mon();
    do_start(4, 1);
    wait_all("t1_all_done", 100);
    chk_addrs("t1", 4);
    if (rd_cyc.size() == 4) chk("t1_rd_consecutive", 32'(rd_cyc[3] - rd_cyc[0]), 3);
    if (rd_cyc.size() == 4) chk("t1_pv_lag", 32'(first_pv - rd_cyc[0]), 1);
    chk("t1_pv_cnt", 32'(pv_cnt), 4);
    chk("t1_noop_cnt", 32'(noop_cnt), 8);
    chk("t1_noop_follow", 32'(first_noop - first_pv), 4);
    chk("t1_noop_contig", 32'(last_noop - first_noop), 7);
    chk("t1_step_done", 32'(sd_cnt), 1);
    chk("t1_all_done_cnt", 32'(ad_cnt), 1);
    chk("t1_step_count", 32'(step_count_o), 1);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_busy_after", 32'(busy_o), 0);

    // 2: three steps, solver not ready for 20 cycles before each.
    clear_mon();
    solver_ready_i = 1'b0;
    do_start(3, 3);
    for (int s = 0; s < 3; s++) begin
      solver_ready_i = 1'b0;
      repeat (20) @(negedge clk);
      chk($sformatf("t2_norд_step%0d", s), 32'(addr_log.size()), 32'(3 * s));
      solver_ready_i = 1'b1;
      wait_step($sformatf("t2_step%0d_seen", s), 100);
    end
    solver_ready_i = 1'b0;
    wait_all("t2_all_done", 20);
    solver_ready_i = 1'b1;
    chk("t2_rd_while_low", 32'(rd_low), 0);
    chk("t2_step_done", 32'(sd_cnt), 3);
    chk("t2_step_count", 32'(step_count_o), 3);
    chk("t2_rd_cnt", 32'(addr_log.size()), 9);
    chk("t2_busy_after", 32'(busy_o), 0);

    // 3: upload stall for 5 cycles while address 2 is presented.
    clear_mon();
    do_start(6, 1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (prd_en_o && prd_addr_o == 16'd2) begin
        hit = 1'b1;
        ui_busy_i = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("t3_reached_idx2", 32'(hit), 1);
    repeat (5) @(posedge clk);
    #1;
    ui_busy_i = 1'b0;
    wait_all("t3_all_done", 100);
    chk_addrs("t3", 6);
    if (rd_cyc.size() == 6) chk("t3_stall_gap", 32'(rd_cyc[2] - rd_cyc[1]), 6);
    chk("t3_pv_cnt", 32'(pv_cnt), 6);

    // 4: zero pairs finishes at once.
    clear_mon();
    do_start(0, 2);
    repeat (2) @(negedge clk);
    #1;
    chk("t4_all_done_cnt", 32'(ad_cnt), 1);
    repeat (4) @(posedge clk); #1;
    chk("t4_no_rd", 32'(addr_log.size()), 0);
    chk("t4_no_pv", 32'(pv_cnt + noop_cnt), 0);
    chk("t4_busy", 32'(busy_o), 0);

    // 5: spurious done sets a sticky error, cleared by next start.
    clear_mon();
    solver_ready_i = 1'b0;
    do_start(2, 1);
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    chk("t5_err_set", 32'(err_o), 1);
    solver_ready_i = 1'b1;
    wait_all("t5_all_done", 100);
    chk("t5_err_sticky", 32'(err_o), 1);
    chk("t5_step_done", 32'(sd_cnt), 1);
    do_start(1, 1);
    chk("t5_err_cleared", 32'(err_o), 0);
    wait_all("t5b_all_done", 100);

    // 6: reset during DRAIN abandons the step.
    clear_mon();
    do_start(2, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (noop_cnt == 8) hit = 1'b1;
    end
    chk("t6_reached_drain", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_pv", 32'(push_valid_o), 0);
    chk("t6_rst_step_count", 32'(step_count_o), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("t6_no_step_done", 32'(sd_cnt + ad_cnt), 0);
    clear_mon();
    do_start(3, 1);
    wait_all("t6_clean_all_done", 100);
    chk("t6_clean_pv", 32'(pv_cnt), 3);
    chk("t6_clean_step_done", 32'(sd_cnt), 1);
    chk("t6_clean_step_count", 32'(step_count_o), 1);
    chk("t6_clean_err", 32'(err_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
